// File: rtl/fifo_load_ctrl.sv
// fifo_load_ctrl
// Drives the per-lane write/shift enables of one weight/input FIFO bank in
// front of the MMU. A sequence is requested with start. Lanes are then
// enabled either all together (flat) or as a diagonal wavefront (stagger).
// In stagger mode either lane 0 or the top lane can lead.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; enables low, busy low
//   RUN   | step counter t advancing; fifo_en shows the pattern for t
//   DONE  | single-cycle completion; done high, a new start may chain in
//
// All outputs are flops, so no input reaches an output combinationally.

module fifo_load_ctrl #(
    parameter  int FIFO_WIDTH = 16,
    parameter  int MAX_LEN    = 16,
    localparam int LEN_W      = $clog2(MAX_LEN + 1),
    localparam int CNT_W      = $clog2(FIFO_WIDTH + MAX_LEN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stagger,
    input  logic                  lsb_first,
    input  logic [LEN_W-1:0]      len,
    input  logic                  abort,
    output logic [FIFO_WIDTH-1:0] fifo_en,
    output logic                  busy,
    output logic                  done
);

    // One extra bit on the lane window compares, so that offset + len can
    // never wrap.
    localparam int                CMP_W       = CNT_W + 1;
    localparam logic [LEN_W-1:0]  MAX_LEN_V   = LEN_W'(MAX_LEN);
    localparam logic [CMP_W-1:0]  STAGGER_PAD = CMP_W'(FIFO_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q,     state_d;
    logic [CNT_W-1:0]        t_q,         t_d;
    logic                    stagger_q,   stagger_d;
    logic                    lsb_first_q, lsb_first_d;
    logic [LEN_W-1:0]        len_q,       len_d;
    logic [FIFO_WIDTH-1:0]   fifo_en_q,   fifo_en_d;
    logic                    busy_q,      busy_d;
    logic                    done_q,      done_d;

    logic [LEN_W-1:0]        len_sat;
    logic [CMP_W-1:0]        last_t;
    logic                    at_last;
    logic [FIFO_WIDTH-1:0]   lane_hit;

    // Lane k is on while offset <= t < offset + len. The offset is k when
    // lane 0 leads, or FIFO_WIDTH-1-k when the top lane leads. Flat mode
    // turns every lane on.
    function automatic logic [FIFO_WIDTH-1:0] lane_pattern(
        input logic [CNT_W-1:0] t,
        input logic             stg,
        input logic             lsb,
        input logic [LEN_W-1:0] l
    );
        logic [FIFO_WIDTH-1:0] pat;
        logic [CMP_W-1:0]      t_ext;
        logic [CMP_W-1:0]      off;
        logic [CMP_W-1:0]      lim;
        pat   = '0;
        t_ext = {1'b0, t};
        for (int k = 0; k < FIFO_WIDTH; k++) begin
            off    = lsb ? CMP_W'(k) : CMP_W'(FIFO_WIDTH - 1 - k);
            lim    = off + CMP_W'(l);
            pat[k] = !stg || ((t_ext >= off) && (t_ext < lim));
        end
        return pat;
    endfunction

    // Clamp an oversized burst request before it is latched.
    always_comb begin
        len_sat = (len > MAX_LEN_V) ? MAX_LEN_V : len;
    end

    // Final step index of the running sequence, taken from the latched
    // configuration. len_q is nonzero whenever RUN is entered, so the -1
    // cannot underflow while the result is in use.
    always_comb begin
        if (stagger_q) begin
            last_t = STAGGER_PAD + CMP_W'(len_q) - CMP_W'(1);
        end else begin
            last_t = CMP_W'(len_q) - CMP_W'(1);
        end
        at_last = ({1'b0, t_q} == last_t);
    end

    // Next-state logic: start handling, config latch, step counter, abort.
    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        stagger_d   = stagger_q;
        lsb_first_d = lsb_first_q;
        len_d       = len_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                // A simultaneous abort cancels the request outright.
                if (start && !abort) begin
                    stagger_d   = stagger;
                    lsb_first_d = lsb_first;
                    len_d       = len_sat;
                    t_d         = '0;
                    // An empty burst has nothing to emit, so it goes
                    // straight to DONE.
                    state_d     = (len_sat == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (at_last) begin
                    state_d = ST_DONE;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Lane enables for the step being entered. The pattern is computed from
    // the next-cycle counter and config, so fifo_en appears one cycle after
    // start is sampled.
    always_comb begin
        lane_hit = lane_pattern(t_d, stagger_d, lsb_first_d, len_d);
    end

    // Registered outputs are derived purely from the upcoming state.
    always_comb begin
        fifo_en_d = (state_d == ST_RUN) ? lane_hit : '0;
        busy_d    = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    // State, counter, latched config and output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            t_q         <= '0;
            stagger_q   <= 1'b0;
            lsb_first_q <= 1'b0;
            len_q       <= '0;
            fifo_en_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            stagger_q   <= stagger_d;
            lsb_first_q <= lsb_first_d;
            len_q       <= len_d;
            fifo_en_q   <= fifo_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign fifo_en = fifo_en_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_fifo_load_ctrl.sv
// Directed bench for fifo_load_ctrl. There are two instances: a small one
// (4 lanes, MAX_LEN 8) and the default-parameter one (16 lanes, MAX_LEN 16).
module tb_fifo_load_ctrl;

    logic        clk = 1'b0;
    logic        reset;

    logic        a_start, a_stagger, a_lsb, a_abort;
    logic [3:0]  a_len;
    logic [3:0]  a_en;
    logic        a_busy, a_done;

    logic        b_start, b_stagger, b_lsb, b_abort;
    logic [4:0]  b_len;
    logic [15:0] b_en;
    logic        b_busy, b_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fifo_load_ctrl #(.FIFO_WIDTH(4), .MAX_LEN(8)) u_small (
        .clk(clk), .reset(reset), .start(a_start), .stagger(a_stagger),
        .lsb_first(a_lsb), .len(a_len), .abort(a_abort),
        .fifo_en(a_en), .busy(a_busy), .done(a_done)
    );

    fifo_load_ctrl u_wide (
        .clk(clk), .reset(reset), .start(b_start), .stagger(b_stagger),
        .lsb_first(b_lsb), .len(b_len), .abort(b_abort),
        .fifo_en(b_en), .busy(b_busy), .done(b_done)
    );

    // Invariants, sampled mid-cycle on both instances.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            n_checks++;
            if ((a_busy & a_done) !== 1'b0 || (b_busy & b_done) !== 1'b0) begin
                n_errors++;
                $display("FAIL inv_busy_done: a=%b%b b=%b%b want not both 1", a_busy, a_done, b_busy, b_done);
            end
            n_checks++;
            if ((!a_busy && a_en !== 4'b0) || (!b_busy && b_en !== 16'h0)) begin
                n_errors++;
                $display("FAIL inv_en_idle: a_en=%b b_en=%h want 0 when not busy", a_en, b_en);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        a_start = 0; a_stagger = 0; a_lsb = 0; a_abort = 0; a_len = 0;
        b_start = 0; b_stagger = 0; b_lsb = 0; b_abort = 0; b_len = 0;
        #3;
        n_checks++;
        if (a_en !== 4'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_small: en=%b busy=%b done=%b want 0000 0 0", a_en, a_busy, a_done);
        end
        n_checks++;
        if (b_en !== 16'h0 || b_busy !== 1'b0 || b_done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_wide: en=%h busy=%b done=%b want 0 0 0", b_en, b_busy, b_done);
        end
        tick;
        tick;
        reset = 1'b0;
        tick;
        n_checks++;
        if (a_en !== 4'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_idle: en=%b busy=%b done=%b want 0000 0 0", a_en, a_busy, a_done);
        end
    endtask

    task automatic test_stagger_msb;
        logic [3:0] exp [5];
        exp = '{4'b1000, 4'b1100, 4'b0110, 4'b0011, 4'b0001};
        a_stagger = 1; a_lsb = 0; a_len = 4'd2; a_start = 1;
        tick;
        a_start = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick;
            n_checks++;
            if (a_en !== exp[i] || a_busy !== 1'b1 || a_done !== 1'b0) begin
                n_errors++;
                $display("FAIL stagger_msb step %0d: en=%b busy=%b done=%b want %b 1 0", i, a_en, a_busy, a_done, exp[i]);
            end
        end
        tick;
        n_checks++;
        if (a_en !== 4'b0 || a_busy !== 1'b0 || a_done !== 1'b1) begin
            n_errors++;
            $display("FAIL stagger_msb_done: en=%b busy=%b done=%b want 0000 0 1", a_en, a_busy, a_done);
        end
        tick;
        n_checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL stagger_msb_idle: busy=%b done=%b want 0 0", a_busy, a_done);
        end
    endtask

    task automatic test_stagger_lsb;
        logic [3:0] exp [7];
        exp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        a_stagger = 1; a_lsb = 1; a_len = 4'd4; a_start = 1;
        tick;
        a_start = 0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick;
            n_checks++;
            if (a_en !== exp[i] || a_busy !== 1'b1) begin
                n_errors++;
                $display("FAIL stagger_lsb step %0d: en=%b busy=%b want %b 1", i, a_en, a_busy, exp[i]);
            end
        end
        tick;
        n_checks++;
        if (a_en !== 4'b0 || a_busy !== 1'b0 || a_done !== 1'b1) begin
            n_errors++;
            $display("FAIL stagger_lsb_done: en=%b busy=%b done=%b want 0000 0 1", a_en, a_busy, a_done);
        end
        tick;
    endtask

    task automatic test_flat_back_to_back;
        a_stagger = 0; a_lsb = 0; a_len = 4'd3; a_start = 1;
        tick;
        a_start = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick;
            n_checks++;
            if (a_en !== 4'b1111 || a_busy !== 1'b1) begin
                n_errors++;
                $display("FAIL flat step %0d: en=%b busy=%b want 1111 1", i, a_en, a_busy);
            end
        end
        // Request the next burst (len 2) now; it is ignored until DONE.
        a_start = 1; a_len = 4'd2;
        tick;
        n_checks++;
        if (a_en !== 4'b0 || a_busy !== 1'b0 || a_done !== 1'b1) begin
            n_errors++;
            $display("FAIL flat_done: en=%b busy=%b done=%b want 0000 0 1", a_en, a_busy, a_done);
        end
        tick;
        a_start = 0;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) tick;
            n_checks++;
            if (a_en !== 4'b1111 || a_busy !== 1'b1 || a_done !== 1'b0) begin
                n_errors++;
                $display("FAIL b2b step %0d: en=%b busy=%b done=%b want 1111 1 0", i, a_en, a_busy, a_done);
            end
        end
        tick;
        n_checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_done: busy=%b done=%b want 0 1", a_busy, a_done);
        end
        tick;
    endtask

    task automatic test_len_zero;
        for (int m = 0; m < 2; m++) begin
            a_stagger = m[0]; a_lsb = 0; a_len = 4'd0; a_start = 1;
            tick;
            a_start = 0;
            n_checks++;
            if (a_en !== 4'b0 || a_busy !== 1'b0 || a_done !== 1'b1) begin
                n_errors++;
                $display("FAIL len_zero mode %0d: en=%b busy=%b done=%b want 0000 0 1", m, a_en, a_busy, a_done);
            end
            tick;
            n_checks++;
            if (a_busy !== 1'b0 || a_done !== 1'b0) begin
                n_errors++;
                $display("FAIL len_zero_idle mode %0d: busy=%b done=%b want 0 0", m, a_busy, a_done);
            end
        end
    endtask

    task automatic test_len_saturate;
        int         cycles;
        logic [3:0] first_en;
        logic [3:0] last_en;
        a_stagger = 1; a_lsb = 1; a_len = 4'd12; a_start = 1;
        tick;
        a_start = 0;
        cycles = 0;
        first_en = a_en;
        last_en = 4'b0;
        while (a_busy === 1'b1 && cycles < 30) begin
            last_en = a_en;
            cycles++;
            tick;
        end
        n_checks++;
        if (cycles !== 11) begin
            n_errors++;
            $display("FAIL len_sat_cycles: got %0d want 11", cycles);
        end
        n_checks++;
        if (first_en !== 4'b0001 || last_en !== 4'b1000) begin
            n_errors++;
            $display("FAIL len_sat_edges: first=%b last=%b want 0001 1000", first_en, last_en);
        end
        n_checks++;
        if (a_done !== 1'b1) begin
            n_errors++;
            $display("FAIL len_sat_done: got %b want 1", a_done);
        end
        tick;
    endtask

    task automatic test_abort;
        logic [3:0] exp [3];
        exp = '{4'b1000, 4'b1100, 4'b1110};
        a_stagger = 1; a_lsb = 0; a_len = 4'd4; a_start = 1;
        tick;
        a_start = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick;
            n_checks++;
            if (a_en !== exp[i]) begin
                n_errors++;
                $display("FAIL abort_pre step %0d: en=%b want %b", i, a_en, exp[i]);
            end
        end
        a_abort = 1;
        tick;
        a_abort = 0;
        n_checks++;
        if (a_en !== 4'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_stop: en=%b busy=%b done=%b want 0000 0 0", a_en, a_busy, a_done);
        end
        tick;
        n_checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_no_done: busy=%b done=%b want 0 0", a_busy, a_done);
        end
        a_abort = 1; a_start = 1; a_len = 4'd2;
        tick;
        a_abort = 0; a_start = 0;
        n_checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_en !== 4'b0) begin
            n_errors++;
            $display("FAIL abort_with_start: en=%b busy=%b done=%b want 0000 0 0", a_en, a_busy, a_done);
        end
        tick;
    endtask

    task automatic test_start_ignored;
        logic [3:0] exp [5];
        exp = '{4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1000};
        a_stagger = 1; a_lsb = 1; a_len = 4'd2; a_start = 1;
        tick;
        // A new request with a different config arrives mid-sequence.
        a_lsb = 0; a_len = 4'd8;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick;
            if (i == 2) a_start = 0;
            n_checks++;
            if (a_en !== exp[i] || a_busy !== 1'b1) begin
                n_errors++;
                $display("FAIL start_ignored step %0d: en=%b busy=%b want %b 1", i, a_en, a_busy, exp[i]);
            end
        end
        tick;
        n_checks++;
        if (a_done !== 1'b1 || a_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL start_ignored_done: busy=%b done=%b want 0 1", a_busy, a_done);
        end
        tick;
    endtask

    task automatic test_async_reset;
        a_stagger = 1; a_lsb = 0; a_len = 4'd4; a_start = 1;
        tick;
        a_start = 0;
        tick;
        n_checks++;
        if (a_busy !== 1'b1 || a_en !== 4'b1100) begin
            n_errors++;
            $display("FAIL async_pre: en=%b busy=%b want 1100 1", a_en, a_busy);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (a_en !== 4'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: en=%b busy=%b done=%b want 0000 0 0", a_en, a_busy, a_done);
        end
        #1 reset = 1'b0;
        tick;
        tick;
        n_checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL async_after: busy=%b done=%b want 0 0", a_busy, a_done);
        end
    endtask

    task automatic test_wide_stagger;
        int cycles;
        int full_at;
        b_stagger = 1; b_lsb = 0; b_len = 5'd16; b_start = 1;
        tick;
        b_start = 0;
        n_checks++;
        if (b_en !== 16'h8000) begin
            n_errors++;
            $display("FAIL wide_first: en=%h want 8000", b_en);
        end
        cycles = 0;
        full_at = -1;
        while (b_busy === 1'b1 && cycles < 40) begin
            if (b_en === 16'hffff && full_at < 0) full_at = cycles;
            cycles++;
            tick;
        end
        n_checks++;
        if (cycles !== 31) begin
            n_errors++;
            $display("FAIL wide_cycles: got %0d want 31", cycles);
        end
        n_checks++;
        if (full_at !== 15) begin
            n_errors++;
            $display("FAIL wide_full_step: got %0d want 15", full_at);
        end
        n_checks++;
        if (b_done !== 1'b1) begin
            n_errors++;
            $display("FAIL wide_done: got %b want 1", b_done);
        end
        tick;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_stagger_msb;
        test_stagger_lsb;
        test_flat_back_to_back;
        test_len_zero;
        test_len_saturate;
        test_abort;
        test_start_ignored;
        test_async_reset;
        test_wide_stagger;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
